// File: rtl/fn_sw_n.sv
// fn_sw_n: single-stage registered ALU with a valid/ready handshake on both
// sides, an accumulate mode that feeds the result register back as operand A,
// and a wrapping count of accepted operations.
module fn_sw_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zero,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_XNOR = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_NOT  = 3'b110,
    OP_LOAD = 3'b111
  } op_e;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             accept;

  // The output slot is free when empty or being drained this same cycle;
  // depends only on registered state and out_ready, never on in_valid.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Operand selection and result/carry computation for every select code.
  // The extra top bit of the widened add/sub is the carry or, for
  // subtraction, the unsigned borrow (set exactly when op_a < b).
  always_comb begin
    op_a     = acc ? y : a;
    sum_ext  = {1'b0, op_a} + {1'b0, b};
    diff_ext = {1'b0, op_a} - {1'b0, b};
    res      = '0;
    res_c    = 1'b0;
    case (op_e'(sel))
      OP_AND:  res = op_a & b;
      OP_OR:   res = op_a | b;
      OP_XOR:  res = op_a ^ b;
      OP_XNOR: res = ~(op_a ^ b);
      OP_ADD: begin
        res   = sum_ext[WIDTH-1:0];
        res_c = sum_ext[WIDTH];
      end
      OP_SUB: begin
        res   = diff_ext[WIDTH-1:0];
        res_c = diff_ext[WIDTH];
      end
      OP_NOT:  res = ~op_a;
      default: res = b;
    endcase
  end

  // Result register, handshake state and operation counter; reset wins over
  // a simultaneous accept, and a consume without accept keeps y/cout/zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      cout      <= 1'b0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      op_cnt    <= '0;
    end else if (accept) begin
      y         <= res;
      cout      <= res_c;
      zero      <= (res == '0);
      out_valid <= 1'b1;
      op_cnt    <= op_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fn_sw_n.sv
// tb_fn_sw_n: directed checks of fn_sw_n; a second instance with a 4-bit
// counter shares every input so the counter wrap can be observed.
module tb_fn_sw_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] sel;
  logic       acc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       cout;
  logic       zero;
  logic [15:0] op_cnt;

  logic       in_ready4;
  logic       out_valid4;
  logic [7:0] y4;
  logic       cout4;
  logic       zero4;
  logic [3:0] op_cnt4;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_op_y [8] = '{8'h24, 8'hBD, 8'h99, 8'h66, 8'hE1, 8'h69, 8'h5A, 8'h3C};

  fn_sw_n #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .acc(acc), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .cout(cout), .zero(zero), .op_cnt(op_cnt)
  );

  fn_sw_n #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .sel(sel), .acc(acc), .out_valid(out_valid4),
    .out_ready(out_ready), .y(y4), .cout(cout4), .zero(zero4), .op_cnt(op_cnt4)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic iv, input logic [7:0] av,
                               input logic [7:0] bv, input logic [2:0] s,
                               input logic ac, input logic ordy);
    rst       = r;
    in_valid  = iv;
    a         = av;
    b         = bv;
    sel       = s;
    acc       = ac;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("rst_y", 32'(y), 32'h00);
    checkOutput("rst_cout", 32'(cout), 32'h0);
    checkOutput("rst_zero", 32'(zero), 32'h1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_op_cnt", 32'(op_cnt), 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);

    // Each operation on A5/3C.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 8'hA5, 8'h3C, 3'(i), 1'b0, 1'b1);
      tick();
      checkOutput($sformatf("op%0d_y", i), 32'(y), 32'(exp_op_y[i]));
      checkOutput($sformatf("op%0d_cout", i), 32'(cout), 32'h0);
      checkOutput($sformatf("op%0d_valid", i), 32'(out_valid), 32'h1);
    end
    checkOutput("op_cnt_after_8", 32'(op_cnt), 32'd8);

    // Carry and borrow boundaries, then a logic op must clear cout.
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'h01, 3'b100, 1'b0, 1'b1);
    tick();
    checkOutput("add_ff_y", 32'(y), 32'h00);
    checkOutput("add_ff_cout", 32'(cout), 32'h1);
    checkOutput("add_ff_zero", 32'(zero), 32'h1);
    applyStimulus(1'b0, 1'b1, 8'h01, 8'h02, 3'b101, 1'b0, 1'b1);
    tick();
    checkOutput("sub_brw_y", 32'(y), 32'hFF);
    checkOutput("sub_brw_cout", 32'(cout), 32'h1);
    checkOutput("sub_brw_zero", 32'(zero), 32'h0);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'h0F, 3'b000, 1'b0, 1'b1);
    tick();
    checkOutput("and_y", 32'(y), 32'h0F);
    checkOutput("and_cout", 32'(cout), 32'h0);

    // Accumulate from a fresh reset; a is junk and must be ignored.
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 8'hEE, 8'h10, 3'b111, 1'b0, 1'b1);
    tick();
    checkOutput("acc_load_y", 32'(y), 32'h10);
    applyStimulus(1'b0, 1'b1, 8'hEE, 8'h05, 3'b100, 1'b1, 1'b1);
    tick();
    checkOutput("acc1_y", 32'(y), 32'h15);
    tick();
    checkOutput("acc2_y", 32'(y), 32'h1A);
    tick();
    checkOutput("acc3_y", 32'(y), 32'h1F);
    checkOutput("acc_op_cnt", 32'(op_cnt), 32'd4);

    // Consume without accept, then accumulate from the retained y.
    applyStimulus(1'b0, 1'b0, 8'hEE, 8'h05, 3'b100, 1'b1, 1'b1);
    tick();
    checkOutput("consume_valid", 32'(out_valid), 32'h0);
    checkOutput("consume_y_hold", 32'(y), 32'h1F);
    applyStimulus(1'b0, 1'b1, 8'hEE, 8'h01, 3'b100, 1'b1, 1'b1);
    tick();
    checkOutput("acc_after_consume_y", 32'(y), 32'h20);
    checkOutput("acc_after_consume_cnt", 32'(op_cnt), 32'd5);

    // Backpressure: drain first, then hold in_valid with out_ready low.
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'b111, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h77, 3'b111, 1'b0, 1'b0);
    #1;
    checkOutput("bp_ready_empty", 32'(in_ready), 32'h1);
    tick();
    checkOutput("bp_first_y", 32'(y), 32'h77);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h88, 3'b111, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("bp_stall%0d_ready", i), 32'(in_ready), 32'h0);
      checkOutput($sformatf("bp_stall%0d_y", i), 32'(y), 32'h77);
      checkOutput($sformatf("bp_stall%0d_valid", i), 32'(out_valid), 32'h1);
    end
    checkOutput("bp_stall_cnt", 32'(op_cnt), 32'd6);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h88, 3'b111, 1'b0, 1'b1);
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("bp_release_y", 32'(y), 32'h88);
    checkOutput("bp_release_cnt", 32'(op_cnt), 32'd7);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h99, 3'b111, 1'b0, 1'b1);
    tick();
    checkOutput("b2b1_y", 32'(y), 32'h99);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'hAA, 3'b111, 1'b0, 1'b1);
    tick();
    checkOutput("b2b2_y", 32'(y), 32'hAA);
    checkOutput("b2b2_valid", 32'(out_valid), 32'h1);
    checkOutput("b2b2_cnt", 32'(op_cnt), 32'd9);

    // Reset during an accept with a valid result pending.
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h55, 3'b111, 1'b0, 1'b1);
    #1;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("midrst_y", 32'(y), 32'h00);
    checkOutput("midrst_valid", 32'(out_valid), 32'h0);
    checkOutput("midrst_zero", 32'(zero), 32'h1);
    checkOutput("midrst_cnt", 32'(op_cnt), 32'd0);

    // Counter wrap on the 4-bit instance.
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h42, 3'b111, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) tick();
    checkOutput("wrap_cnt4", 32'(op_cnt4), 32'd1);
    checkOutput("wrap_cnt16", 32'(op_cnt), 32'd17);
    checkOutput("wrap_y4", 32'(y4), 32'h42);
    checkOutput("wrap_zero4", 32'(zero4), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fn_sw_n.md
FN_SW_N -- requirements
Module: fn_sw_n

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-002 Parameter: CNT_W, default 16, width of the accepted-operation counter.
REQ-003 Synchronous reset: one clock; reset is synchronous and active-high.
REQ-004 Port list:
- clk  in  1  rising-edge clock, sole clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op valid.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sel  in  3  operation select.
- acc  in  1  1 = operand A taken from current y instead of a.
- out_valid  out  1  y/cout/zero hold a valid result.
- out_ready  in  1  downstream consumes result.
- y  out  WIDTH  registered result.
- cout  out  1  registered carry/borrow (ADD/SUB only, else 0).
- zero  out  1  registered flag, 1 when y == 0.
- op_cnt  out  CNT_W  count of accepted operations.

Function
REQ-005 Operation select; opA = acc ? y : a:
- sel=000: opA & b.
- sel=001: opA | b.
- sel=010: opA ^ b.
- sel=011: ~(opA ^ b).
- sel=100: opA + b mod 2^WIDTH; cout = carry out of bit WIDTH-1.
- sel=101: opA - b mod 2^WIDTH; cout = 1 when opA < b (borrow), unsigned.
- sel=110: ~opA.
- sel=111: b (load).
REQ-006 Accept condition: in_valid && in_ready, sampled at the rising edge of clk.
REQ-007 in_ready is combinational: !out_valid || out_ready; no combinational path from in_valid to in_ready.
REQ-008 On accept, y, cout and zero load the new result at that edge; latency is 1 cycle, and out_valid = 1 the following cycle.
REQ-009 Result consumption: when out_valid && out_ready with no accept, out_valid clears to 0 at the edge; y, cout and zero retain their values.
REQ-010 Simultaneous consume and accept: out_valid stays 1, new result loaded; full throughput of 1 op/cycle.
REQ-011 Stall: while out_valid && !out_ready, y, cout, zero and out_valid hold stable and in_ready = 0; inputs are ignored.
REQ-012 Accumulate operand: with acc=1, opA is the y register value at the accept edge, even if out_valid = 0 (already consumed).
REQ-013 Operation counter: op_cnt increments by 1 on every accept and wraps from 2^CNT_W-1 to 0.
REQ-014 Carry flag scope: cout = 0 for all sel other than 100/101.
REQ-015 No X propagation: unused sel codes do not exist, and all 8 codes are defined.

Reset
REQ-016 Reset values while rst=1 at an edge: y = 0, cout = 0, zero = 1, out_valid = 0, op_cnt = 0.
REQ-017 Reset priority: rst has priority over a simultaneous accept; that operation is dropped and not counted.
REQ-018 in_ready during reset: in_ready = 1 during and after reset, per REQ-007 with out_valid = 0.

Verification (WIDTH=8)
REQ-019 Each op: a=0xA5, b=0x3C, acc=0, out_ready=1, sel 000..111 -> y = 0x24, 0xBD, 0x99, 0x66, 0xE1 (cout=0), 0x69 (cout=0), 0x5A, 0x3C, each one cycle after accept.
REQ-020 Carry/borrow: ADD 0xFF+0x01 -> y=0x00, cout=1, zero=1; SUB 0x01-0x02 -> y=0xFF, cout=1, zero=0.
REQ-021 Accumulate: load 0x10 (sel=111), then three ADD with acc=1, b=0x05 -> y = 0x15, 0x1A, 0x1F; op_cnt = 4.
REQ-022 Backpressure: out_ready=0 with in_valid held for 5 cycles -> one accept only, in_ready=0, y stable; raise out_ready -> next accept in that same cycle, and back-to-back results at 1/cycle.
REQ-023 Reset mid-stream: rst=1 during accept with out_valid=1 -> next cycle y=0, out_valid=0, zero=1, op_cnt=0.
REQ-024 Counter wrap: CNT_W=4, 17 accepts -> op_cnt = 1.
